// File: rtl/seg_history_scan_pkg.sv
// seg_history_scan_pkg
//   Shared constants for the seven-segment history display:
//   - active-low segment encodings for hex digits 0-F, ordered {g,f,e,d,c,b,a}
//   - SEG_OFF (all segments dark) and AN_OFF (all digits disabled)
//   - history depth and the digit-enable helper
package seg_history_scan_pkg;

    localparam int unsigned HIST_DEPTH = 4;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Active-low one-hot enable for digit idx.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_history_scan_hex7seg.sv
// hex7seg
//   Combinational hex to active-low seven-segment decoder.
//   Ports:
//     val  in  4  hex digit value
//     seg  out 7  active-low cathodes {g,f,e,d,c,b,a}
module hex7seg
    import seg_history_scan_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (val)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_history_scan.sv
// seg_history_scan
//   Records each change of the selected 4-bit value into a 4-deep history
//   and time-multiplexes it onto a 4-digit common-anode display. Digit 0
//   shows the newest value (decimal point lit), digit 3 the oldest.
//   Parameters:
//     REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//   Ports:
//     clk    in  1  system clock
//     rst_n  in  1  synchronous active-low reset
//     s_op   in  4  selected value from the upstream stage
//     hold   in  1  freeze history while high
//     an     out 4  digit enables, active-low
//     seg    out 7  segment cathodes, active-low {g,f,e,d,c,b,a}
//     dp     out 1  decimal point, active-low
//   Build option:
//     SEG_BLANK_INVALID_EN  blank digits whose history slot is not yet valid
module seg_history_scan
    import seg_history_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] s_op,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);

    logic [3:0]            h [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] v;
    logic [3:0]            s_prev;
    logic                  primed;
    logic [RW-1:0]         rcnt;
    logic [1:0]            idx;

    logic [3:0] digit_val;
    logic [6:0] dec_seg;

    assign digit_val = h[idx];

    hex7seg u_hex7seg (
        .val (digit_val),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) h[i] <= '0;
            v      <= '0;
            s_prev <= '0;
            primed <= 1'b0;
            rcnt   <= '0;
            idx    <= '0;
            an     <= AN_OFF;
            seg    <= SEG_OFF;
            dp     <= 1'b1;
        end else begin
            if (rcnt == RCNT_LAST) begin
                rcnt <= '0;
                idx  <= idx + 2'd1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end

            if (!primed) begin
                h[0]   <= s_op;
                v[0]   <= 1'b1;
                s_prev <= s_op;
                primed <= 1'b1;
            end else if (!hold && (s_op != s_prev)) begin
                for (int unsigned i = HIST_DEPTH - 1; i > 0; i--) h[i] <= h[i-1];
                h[0]   <= s_op;
                v      <= {v[HIST_DEPTH-2:0], 1'b1};
                s_prev <= s_op;
            end

            // Display stays dark until the first sample has been captured,
            // so the first lit digit appears on the second edge after reset.
            if (!primed) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an <= an_select(idx);
`ifdef SEG_BLANK_INVALID_EN
                if (!v[idx]) begin
                    seg <= SEG_OFF;
                    dp  <= 1'b1;
                end else begin
                    seg <= dec_seg;
                    dp  <= (idx != 2'd0);
                end
`else
                seg <= dec_seg;
                dp  <= (idx != 2'd0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg_history_scan.sv
module tb_seg_history_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
`ifdef SEG_BLANK_INVALID_EN
    localparam logic [6:0] SINV = 7'b1111111;
`else
    localparam logic [6:0] SINV = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] s_op = 4'h0;
    logic       hold = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];
    int         cap_bad;
    logic [6:0] exp_seg [4];

    seg_history_scan #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_op  (s_op),
        .hold  (hold),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    // Hold reset for two edges with s_op preset, release on a falling edge.
    task automatic apply_reset(input logic [3:0] val);
        @(negedge clk);
        rst_n = 1'b0;
        s_op  = val;
        hold  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Record what each digit displays over n cycles; count non-one-hot an.
    task automatic capture(input int n);
        for (int i = 0; i < 4; i++) begin
            cap_seg[i] = 'x;
            cap_dp[i]  = 1'bx;
        end
        cap_bad = 0;
        repeat (n) begin
            @(negedge clk);
            case (an)
                4'b1110: begin cap_seg[0] = seg; cap_dp[0] = dp; end
                4'b1101: begin cap_seg[1] = seg; cap_dp[1] = dp; end
                4'b1011: begin cap_seg[2] = seg; cap_dp[2] = dp; end
                4'b0111: begin cap_seg[3] = seg; cap_dp[3] = dp; end
                default: cap_bad++;
            endcase
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        s_op  = 4'h3;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);  // edge 1 after release
        checks++;
        if (an !== 4'b1111) begin
            errors++;
            $display("FAIL first_edge_dark: an=%b, required 1111", an);
        end
        @(negedge clk);  // edge 2
        checks++;
        if (an !== 4'b1110 || seg !== S3 || dp !== 1'b0) begin
            errors++;
            $display("FAIL first_digit: an=%b seg=%b dp=%b, required an=1110 seg=%b dp=0", an, seg, dp, S3);
        end
    endtask

    task automatic test_scan;
        logic [3:0] exp_an [4];
        exp_an[0] = 4'b1101; exp_an[1] = 4'b1011; exp_an[2] = 4'b0111; exp_an[3] = 4'b1110;
        repeat (3) @(negedge clk);  // edge 5
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (an !== exp_an[k]) begin
                errors++;
                $display("FAIL scan_step%0d: an=%b, required %b", k, an, exp_an[k]);
            end
            repeat (4) @(negedge clk);
        end
        capture(20);
        exp_seg[0] = S3; exp_seg[1] = SINV; exp_seg[2] = SINV; exp_seg[3] = SINV;
        checks++;
        if (cap_bad !== 0) begin
            errors++;
            $display("FAIL scan_onehot: bad an samples=%0d, required 0", cap_bad);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i] || cap_dp[i] !== (i != 0)) begin
                errors++;
                $display("FAIL scan_digit%0d: seg=%b dp=%b, required seg=%b dp=%b", i, cap_seg[i], cap_dp[i], exp_seg[i], (i != 0));
            end
        end
    endtask

    task automatic test_shift;
        logic [3:0] vals [4];
        vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h3; vals[3] = 4'h4;
        for (int k = 0; k < 4; k++) begin
            s_op = vals[k];
            repeat (10) @(negedge clk);
        end
        capture(20);
        exp_seg[0] = S4; exp_seg[1] = S3; exp_seg[2] = S2; exp_seg[3] = S1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i] || cap_dp[i] !== (i != 0)) begin
                errors++;
                $display("FAIL shift4_digit%0d: seg=%b dp=%b, required seg=%b dp=%b", i, cap_seg[i], cap_dp[i], exp_seg[i], (i != 0));
            end
        end
        s_op = 4'h5;
        capture(20);
        exp_seg[0] = S5; exp_seg[1] = S4; exp_seg[2] = S3; exp_seg[3] = S2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL shift5_digit%0d: seg=%b, required %b", i, cap_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_hold;
        hold = 1'b1;
        s_op = 4'h6; repeat (3) @(negedge clk);
        s_op = 4'h7; repeat (3) @(negedge clk);
        s_op = 4'h8;
        capture(20);
        exp_seg[0] = S5; exp_seg[1] = S4; exp_seg[2] = S3; exp_seg[3] = S2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL hold_frozen_digit%0d: seg=%b, required %b", i, cap_seg[i], exp_seg[i]);
            end
        end
        hold = 1'b0;
        capture(20);
        exp_seg[0] = S8; exp_seg[1] = S5; exp_seg[2] = S4; exp_seg[3] = S3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL hold_release_digit%0d: seg=%b, required %b", i, cap_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_no_change;
        s_op = 4'hA;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            s_op = 4'hA;  // re-driving the same value must not shift
            @(negedge clk);
        end
        capture(20);
        exp_seg[0] = SA; exp_seg[1] = S8; exp_seg[2] = S5; exp_seg[3] = S4;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i]) begin
                errors++;
                $display("FAIL nochange_digit%0d: seg=%b, required %b", i, cap_seg[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_reset_midscan;
        int  waited;
        waited = 0;
        while (an !== 4'b1011 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL midscan_wait: an=%b, required 1011 within 40 cycles", an);
        end
        rst_n = 1'b0;
        s_op  = 4'h9;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL midscan_reset: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== S9 || dp !== 1'b0) begin
            errors++;
            $display("FAIL midscan_reload: an=%b seg=%b dp=%b, required an=1110 seg=%b dp=0", an, seg, dp, S9);
        end
        capture(20);
        exp_seg[0] = S9; exp_seg[1] = SINV; exp_seg[2] = SINV; exp_seg[3] = SINV;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i] || cap_dp[i] !== (i != 0)) begin
                errors++;
                $display("FAIL midscan_digit%0d: seg=%b dp=%b, required seg=%b dp=%b", i, cap_seg[i], cap_dp[i], exp_seg[i], (i != 0));
            end
        end
    endtask

    task automatic test_blank;
        apply_reset(4'hF);
        capture(24);
        exp_seg[0] = SF; exp_seg[1] = SINV; exp_seg[2] = SINV; exp_seg[3] = SINV;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i] || cap_dp[i] !== (i != 0)) begin
                errors++;
                $display("FAIL blank_digit%0d: seg=%b dp=%b, required seg=%b dp=%b", i, cap_seg[i], cap_dp[i], exp_seg[i], (i != 0));
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_shift;
        test_hold;
        test_no_change;
        test_reset_midscan;
        test_blank;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_history_scan.md
# seg_history_scan

Downstream display stage for the auto/manual 4-bit selector. Watches the selected 4-bit value `s_op`, records each new value into a 4-deep change history, and time-multiplexes the history onto a 4-digit common-anode seven-segment display. The newest value is on digit 0 and the oldest on digit 3. It feeds the board anode and cathode pins directly.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range is 2 and up.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `s_op`  in  4  selected value from the upstream auto/manual stage.
- `hold`  in  1  when 1, the history is frozen and changes on `s_op` are ignored.
- `an`  out  4  digit enables, active-low; bit i enables digit i.
- `seg`  out  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point, active-low.

## Operation
History registers:
- `h0..h3` are 4-bit value registers. `v[3:0]` holds a valid bit per slot. `s_prev` is 4 bits. `primed` is 1 bit.
- First cycle after reset (`primed`=0), regardless of `hold`:
  - `h0` ← `s_op`, `v[0]` ← 1, `s_prev` ← `s_op`, `primed` ← 1.
- Afterwards, when `hold`=0 and `s_op` ≠ `s_prev`:
  - shift: `h3`←`h2`, `h2`←`h1`, `h1`←`h0`, `h0`←`s_op`
  - `v` ← {`v[2:0]`,1}
  - `s_prev` ← `s_op`
- When `hold`=1, all history state holds. After `hold` falls, one shift occurs if `s_op` ≠ `s_prev`. Intermediate values seen during the hold are lost.
- Simultaneous `hold`=1 and a change: `hold` wins.
- Equal consecutive samples never shift.

Scan:
- `rcnt` counts 0..`REFRESH_DIV`-1 and wraps. At terminal count, `idx` (2 bits) increments, wrapping 3→0.
- Digit `idx` shows `h[idx]` through the hex decoder (0–F, standard shapes). Examples: 0=7'b1000000, 8=7'b0000000, A=7'b0001000, F=7'b0001110.
- `dp` is lit (0) only while digit 0 is enabled, marking the newest value.
- A slot with `v[idx]`=0 shows 0 unless the blanking option below is compiled in.

## Timing
- `an`, `seg` and `dp` are registered. They reflect the `idx`, `h*` and `v` values of the previous cycle (1-cycle latency).
- A change on `s_op` at edge k updates `h0` at edge k. It appears on `seg` at edge k+1 if digit 0 is active at that point; otherwise it appears on the next digit-0 slot.
- Reset values:
  - `an`=4'b1111, `seg`=7'b1111111, `dp`=1
  - `h*`=0, `v`=0, `s_prev`=0, `primed`=0, `rcnt`=0, `idx`=0
- First enabled digit after reset: `an`=4'b1110, driven at edge 2 after `rst_n` rises.
- Exactly one `an` bit is low at any time after the first post-reset edge.
- Reset asserted mid-scan or mid-shift: on that edge, every register returns to its reset value. No partial shift is retained.

## Configuration
- `SEG_BLANK_INVALID_EN` defined: a digit whose `v` bit is 0 drives `seg`=7'b1111111 and `dp`=1 while its `an` bit is low. After reset, only digit 0 is lit until further changes occur.
- Not defined: `v` still exists, but invalid slots display their register value (0).

## Structure
- Shared package holds:
  - the segment encodings for 0–F and SEG_OFF (7'b1111111)
  - the AN_OFF constant (4'b1111)
  - the history depth (4)
- One sub-module: `hex7seg`, a combinational 4-bit to active-low 7-bit decoder, instantiated once after the history mux.

## Test plan
Run with `REFRESH_DIV`=4.
1. Reset, then `s_op`=4'h3 steady → `h0`=3, `v`=4'b0001. `an` cycles 1110→1101→1011→0111 every 4 cycles. `seg`=7'b0110000 with `dp`=0 on digit 0.
2. Drive `s_op` 1, 2, 3, 4, each held 10 cycles → digits 0..3 show 4, 3, 2, 1 and `v`=4'b1111. A fifth value 5 drops the 1.
3. `hold`=1, then `s_op` 6→7→8 → history unchanged. Release `hold` with `s_op`=8 → single shift, `h0`=8, `h1`=5.
4. `s_op` toggles A→A (no change) over 20 cycles → no shift; `h1` unchanged.
5. Assert `rst_n`=0 mid-scan with `idx`=2 → next edge gives `an`=1111, `seg`=1111111, `v`=0. The first post-reset sample is reloaded.
6. With `SEG_BLANK_INVALID_EN` defined, reset and `s_op`=F → digits 1–3 blank, digit 0 shows 7'b0001110. Without the macro, digits 1–3 show 7'b1000000.
